ntt_host_seq: RTL and testbench
===============================

Name: ntt_host_seq

Overview:
- Hardware host-side driver for the NTT core's serial load/start/unload protocol. It is the transmitting end of that protocol.
- Reads twiddles, inverse twiddles, parameters and input coefficients from a source RAM, then streams them into the NTT core.
- Pulses start, waits for done, then captures the RING_SIZE output words into a sink RAM.
- Replaces the behavioural stimulus sequence so the core can run self-contained on FPGA.

Parameters:
- DATA_SIZE_ARB, 16, data word width.
- RING_SIZE, 1024, coefficients per polynomial.
- PE_NUMBER, 8, NTT core PE count; used only to size the twiddle stream.
- GAP_CYCLES, 5, idle cycles inserted after each stream.
- TIMEOUT, 65535, maximum cycles spent waiting for done.
- Derived, not overridable:
  - W_COUNT = ((RING_SIZE/PE_NUMBER - 1) + log2(PE_NUMBER)) * PE_NUMBER, which is 1040 at defaults.
  - SRC_WORDS = 2*W_COUNT + 2 + RING_SIZE.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  one-cycle command pulse; ignored while busy.
- skip_w  input  1  sampled with go; 1 = skip the twiddle/param load phase.
- busy  output  1  high from the cycle after an accepted go until finished.
- finished  output  1  one-cycle pulse at the end of a run.
- timeout_err  output  1  sticky flag; cleared by the next accepted go.
- src_rd  output  1  source RAM read enable.
- src_addr  output  clog2(SRC_WORDS)  source RAM address.
- src_data  input  DATA_SIZE_ARB  source RAM read data, valid exactly 1 cycle after src_rd.
- load_w  output  1  to core: twiddle-load pulse.
- load_data  output  1  to core: data-load pulse.
- start  output  1  to core: start pulse.
- din  output  DATA_SIZE_ARB  to core: serial input word.
- done  input  1  from core: result ready.
- dout  input  DATA_SIZE_ARB  from core: serial output word.
- snk_we  output  1  sink RAM write enable.
- snk_addr  output  clog2(RING_SIZE)  sink RAM write address.
- snk_data  output  DATA_SIZE_ARB  sink RAM write data.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, every output 0, counters 0.
  - Applies mid-run too; load_w, load_data and start drop immediately.
  - No partial-run recovery; a new go is required.
- Source map:
  - [0, W_COUNT): w.
  - [W_COUNT, 2W_COUNT): winv.
  - 2W_COUNT: q (param 1).
  - 2W_COUNT+1: n_inv (param 6).
  - 2W_COUNT+2 onward: input coefficients 0..RING_SIZE-1.
- States: IDLE, LW_PULSE, W_STREAM, GAP_W, LD_PULSE, D_STREAM, GAP_D, START, WAIT_DONE, CAPTURE, FIN.
- IDLE: go=1 -> LW_PULSE, or LD_PULSE if skip_w=1. busy rises the next cycle.
- LW_PULSE: load_w=1 for exactly one cycle (cycle L).
  - din carries source word k at cycle L+1+k, for k = 0..2W_COUNT+1.
  - Reads are prefetched so din changes every cycle with no bubbles; the first src_rd is issued in cycle L-1 or L.
- W_STREAM ends after the last param word.
  - Then GAP_W holds GAP_CYCLES cycles with din=0.
  - Then LD_PULSE.
- LD_PULSE: load_data=1 for one cycle (cycle D).
  - din carries coefficient j at cycle D+1+j, for j = 0..RING_SIZE-1, read from address 2W_COUNT+2+j.
  - Then GAP_D holds GAP_CYCLES cycles with din=0.
- START: start=1 for one cycle, then WAIT_DONE.
  - done is ignored in the START cycle itself.
- WAIT_DONE: exits on the first cycle T with done=1.
  - The timeout counter increments each cycle.
  - On reaching TIMEOUT: set timeout_err, go to FIN, and skip the capture.
- CAPTURE: output word m is taken from dout at cycle T+1+m.
  - Registered write: snk_we=1, snk_addr=m, snk_data=dout(T+1+m) in cycle T+2+m, for m = 0..RING_SIZE-1.
  - done level is don't-care during capture.
- FIN: finished=1 for one cycle, busy=0 the same cycle, then IDLE.
- din is 0 whenever no stream is active.
- load_w, load_data and start are never high together.
- go during busy is dropped with no effect on the run.
- go and finished in the same cycle: go is ignored; IDLE accepts only from the following cycle.
- snk_addr wraps are impossible; the counter stops at RING_SIZE-1.

Test Plan:
- Full run, defaults, core model returns dout=idx^16'hA5A5 starting 1 cycle after done:
  - load_w high 1 cycle; din = w[0]..w[1039], winv[0]..winv[1039], q, n_inv on 2082 consecutive cycles.
  - 5 gap cycles.
  - load_data high 1 cycle; 1024 data words on consecutive cycles.
  - 5 gap cycles; start high 1 cycle.
  - Sink holds idx^A5A5 at addresses 0..1023; finished pulses once.
- skip_w=1 -> load_w never asserted; load_data is the first pulse; data stream read from address 2082.
- done held low, TIMEOUT=100 -> timeout_err=1 after 100 WAIT_DONE cycles, no snk_we, finished pulses, busy falls.
- go pulsed again during D_STREAM -> stream unchanged, only one finished.
- Reset pulled low mid W_STREAM (word 500) -> all outputs 0 asynchronously; after release and go, a full correct run completes.
- done asserted in the START cycle only and again 40 cycles later -> capture aligned to the later done (T+1).

Source files
------------

// File: rtl/ntt_host_seq.sv
// Host-side sequencer for the NTT core: streams twiddles, params and coefficients
// from a source RAM into the core, starts it, then captures the result into a sink RAM.
module ntt_host_seq #(
    parameter int DATA_SIZE_ARB = 16,
    parameter int RING_SIZE     = 1024,
    parameter int PE_NUMBER     = 8,
    parameter int GAP_CYCLES    = 5,
    parameter int TIMEOUT       = 65535,
    localparam int W_COUNT      = ((RING_SIZE / PE_NUMBER - 1) + $clog2(PE_NUMBER)) * PE_NUMBER,
    localparam int SRC_WORDS    = 2 * W_COUNT + 2 + RING_SIZE,
    localparam int SA_W         = $clog2(SRC_WORDS),
    localparam int SK_W         = $clog2(RING_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     skip_w,
    output logic                     busy,
    output logic                     finished,
    output logic                     timeout_err,
    output logic                     src_rd,
    output logic [SA_W-1:0]          src_addr,
    input  logic [DATA_SIZE_ARB-1:0] src_data,
    output logic                     load_w,
    output logic                     load_data,
    output logic                     start,
    output logic [DATA_SIZE_ARB-1:0] din,
    input  logic                     done,
    input  logic [DATA_SIZE_ARB-1:0] dout,
    output logic                     snk_we,
    output logic [SK_W-1:0]          snk_addr,
    output logic [DATA_SIZE_ARB-1:0] snk_data
);

    localparam int NW      = 2 * W_COUNT + 2;
    localparam int D_BASE  = NW;
    localparam int CNT_MAX = (TIMEOUT > SRC_WORDS) ? TIMEOUT : SRC_WORDS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        IDLE,
        LW_PULSE,
        W_STREAM,
        GAP_W,
        LD_PULSE,
        D_STREAM,
        GAP_D,
        START,
        WAIT_DONE,
        CAPTURE,
        FIN
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rd_vld_p1;
    logic               terr_set, terr_clr, cap_en;

    // One shared counter: stream index, gap length, timeout and capture index.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        src_rd    = 1'b0;
        src_addr  = '0;
        load_w    = 1'b0;
        load_data = 1'b0;
        start     = 1'b0;
        finished  = 1'b0;
        terr_set  = 1'b0;
        terr_clr  = 1'b0;
        cap_en    = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    terr_clr = 1'b1;
                    cnt_n    = '0;
                    state_n  = skip_w ? LD_PULSE : LW_PULSE;
                end
            end
            LW_PULSE: begin
                load_w   = 1'b1;
                src_rd   = 1'b1;
                src_addr = '0;
                cnt_n    = '0;
                state_n  = W_STREAM;
            end
            W_STREAM: begin
                // din shows word cnt while word cnt+1 is being fetched
                if (cnt == CNT_W'(NW - 1)) begin
                    cnt_n   = '0;
                    state_n = GAP_W;
                end else begin
                    src_rd   = 1'b1;
                    src_addr = SA_W'(cnt) + SA_W'(1);
                    cnt_n    = cnt + CNT_W'(1);
                end
            end
            GAP_W: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = LD_PULSE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            LD_PULSE: begin
                load_data = 1'b1;
                src_rd    = 1'b1;
                src_addr  = SA_W'(D_BASE);
                cnt_n     = '0;
                state_n   = D_STREAM;
            end
            D_STREAM: begin
                if (cnt == CNT_W'(RING_SIZE - 1)) begin
                    cnt_n   = '0;
                    state_n = GAP_D;
                end else begin
                    src_rd   = 1'b1;
                    src_addr = SA_W'(D_BASE) + SA_W'(cnt) + SA_W'(1);
                    cnt_n    = cnt + CNT_W'(1);
                end
            end
            GAP_D: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            START: begin
                start   = 1'b1;
                cnt_n   = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    cnt_n   = '0;
                    state_n = CAPTURE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    terr_set = 1'b1;
                    state_n  = FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (cnt == CNT_W'(RING_SIZE - 1)) begin
                    state_n = FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            FIN: begin
                finished = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign din  = rd_vld_p1 ? src_data : '0;

    // p1: read-data valid flag and registered sink write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_vld_p1   <= 1'b0;
            timeout_err <= 1'b0;
            snk_we      <= 1'b0;
            snk_addr    <= '0;
            snk_data    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_vld_p1 <= src_rd;
            if (terr_clr) begin
                timeout_err <= 1'b0;
            end else if (terr_set) begin
                timeout_err <= 1'b1;
            end
            snk_we <= cap_en;
            if (cap_en) begin
                snk_addr <= cnt[SK_W-1:0];
                snk_data <= dout;
            end
        end
    end

endmodule

// File: tb/tb_ntt_host_seq.sv
// Scoreboard bench for ntt_host_seq: per-cycle expected protocol tokens built from
// the load/start/capture rules, popped and compared by an independent monitor.
module tb_ntt_host_seq;

    localparam int DW   = 16;
    localparam int RS   = 1024;
    localparam int PE   = 8;
    localparam int GAP  = 5;
    localparam int TMO  = 100;
    localparam int WC   = ((RS / PE - 1) + $clog2(PE)) * PE;
    localparam int NW   = 2 * WC + 2;
    localparam int SW   = NW + RS;
    localparam int SA_W = $clog2(SW);
    localparam int SK_W = $clog2(RS);

    logic            clk, reset, go, skip_w;
    logic            busy, finished, timeout_err, src_rd;
    logic [SA_W-1:0] src_addr;
    logic [DW-1:0]   src_data;
    logic            load_w, load_data, start;
    logic [DW-1:0]   din;
    logic            done, done_r;
    logic [DW-1:0]   dout;
    logic            snk_we;
    logic [SK_W-1:0] snk_addr;
    logic [DW-1:0]   snk_data;

    ntt_host_seq #(
        .DATA_SIZE_ARB(DW), .RING_SIZE(RS), .PE_NUMBER(PE),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .skip_w(skip_w),
        .busy(busy), .finished(finished), .timeout_err(timeout_err),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .load_w(load_w), .load_data(load_data), .start(start), .din(din),
        .done(done), .dout(dout),
        .snk_we(snk_we), .snk_addr(snk_addr), .snk_data(snk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source and sink RAMs
    logic [DW-1:0] src_mem [SW];
    logic [DW-1:0] snk_mem [RS];
    logic          clr_req;

    always @(posedge clk) begin
        if (src_rd) src_data <= src_mem[src_addr];
    end

    always @(posedge clk) begin
        if (clr_req) begin
            for (int a = 0; a < RS; a++) snk_mem[a] <= DW'(a) ^ 16'h5A5A;
        end else if (snk_we) begin
            snk_mem[snk_addr] <= snk_data;
        end
    end

    // Core model: done after core_dl cycles, then dout = idx ^ A5A5
    int core_dl;
    bit core_early, core_hang;
    assign done = done_r | (core_early & start);

    initial begin
        done_r = 1'b0;
        dout   = '0;
        forever begin
            @(posedge clk); #1;
            if (start && !core_hang) begin
                for (int i = 0; i < core_dl; i++) begin @(posedge clk); #1; end
                done_r = 1'b1;
                for (int m = 0; m < RS; m++) begin
                    @(posedge clk); #1;
                    done_r = 1'b0;
                    dout   = DW'(m) ^ 16'hA5A5;
                end
                @(posedge clk); #1;
                dout = '0;
            end
        end
    end

    typedef struct packed {
        logic            busy, fin, lw, ld, st, terr, we;
        logic [SK_W-1:0] sa;
        logic [DW-1:0]   din, sd;
    } tok_t;

    tok_t  exp_q[$];
    int    total, bad, run_bad, run_cyc, fin_cnt, exp_fin;
    string first_msg;

    function automatic tok_t idle_tok();
        tok_t t;
        t      = '0;
        t.busy = 1'b1;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_trace(input string tag);
        total++;
        if (run_bad != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_trace: %0d bad cycles, %0d tokens unconsumed (want 0,0); first: %s",
                     tag, run_bad, exp_q.size(), first_msg);
        end
    endtask

    // Expected per-cycle protocol from accepted go (cycle after) to the finished pulse
    task automatic build_run(input bit skip, input int dl, input bit hang);
        tok_t t;
        if (!skip) begin
            t = idle_tok(); t.lw = 1'b1; exp_q.push_back(t);
            for (int k = 0; k < NW; k++) begin
                t = idle_tok(); t.din = src_mem[k]; exp_q.push_back(t);
            end
            for (int g = 0; g < GAP; g++) exp_q.push_back(idle_tok());
        end
        t = idle_tok(); t.ld = 1'b1; exp_q.push_back(t);
        for (int j = 0; j < RS; j++) begin
            t = idle_tok(); t.din = src_mem[NW + j]; exp_q.push_back(t);
        end
        for (int g = 0; g < GAP; g++) exp_q.push_back(idle_tok());
        t = idle_tok(); t.st = 1'b1; exp_q.push_back(t);
        if (hang) begin
            for (int i = 0; i < TMO; i++) exp_q.push_back(idle_tok());
            t = '0; t.fin = 1'b1; t.terr = 1'b1; exp_q.push_back(t);
        end else begin
            for (int i = 0; i < dl; i++) exp_q.push_back(idle_tok());
            exp_q.push_back(idle_tok());
            for (int m = 0; m < RS - 1; m++) begin
                t = idle_tok(); t.we = 1'b1; t.sa = SK_W'(m); t.sd = DW'(m) ^ 16'hA5A5;
                exp_q.push_back(t);
            end
            t = '0; t.fin = 1'b1; t.we = 1'b1; t.sa = SK_W'(RS - 1);
            t.sd = DW'(RS - 1) ^ 16'hA5A5;
            exp_q.push_back(t);
        end
    endtask

    // Monitor: every cycle the DUT is active, pop one expected token and compare
    initial begin
        tok_t a, e;
        fin_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset && (busy || finished)) begin
                a = '0;
                a.busy = busy; a.fin = finished; a.lw = load_w; a.ld = load_data;
                a.st = start; a.terr = timeout_err; a.we = snk_we;
                a.din = din;
                if (snk_we) begin a.sa = snk_addr; a.sd = snk_data; end
                if (finished) fin_cnt++;
                if (exp_q.size() == 0) begin
                    if (run_bad == 0) first_msg = $sformatf("cyc %0d unexpected activity %h", run_cyc, a);
                    run_bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        if (run_bad == 0) first_msg = $sformatf("cyc %0d got %h want %h", run_cyc, a, e);
                        run_bad++;
                    end
                end
                run_cyc++;
            end
        end
    end

    task automatic prep(input bit skip, input int dl, input bit early, input bit hang);
        for (int i = 0; i < SW; i++) src_mem[i] = DW'($urandom);
        core_dl = dl; core_early = early; core_hang = hang;
        exp_q.delete();
        run_bad = 0; run_cyc = 0; first_msg = "";
        @(posedge clk); #1; clr_req = 1'b1;
        @(posedge clk); #1; clr_req = 1'b0;
        build_run(skip, dl, hang);
        go = 1'b1; skip_w = skip;
        @(posedge clk); #1;
        go = 1'b0; skip_w = 1'b0;
    endtask

    task automatic run(input bit skip, input int dl, input bit early, input bit hang,
                       input int extra_go, input bit fin_go, input string tag);
        int n, sb;
        prep(skip, dl, early, hang);
        exp_fin++;
        if (extra_go > 0) begin
            n = 0;
            while (!load_data && n < 4000) begin @(posedge clk); #1; n++; end
            repeat (extra_go) @(posedge clk);
            #1; go = 1'b1; skip_w = 1'b1;
            @(posedge clk); #1; go = 1'b0; skip_w = 1'b0;
        end
        n = 0;
        while (!finished && n < 8000) begin @(posedge clk); #1; n++; end
        check({tag, "_finished_seen"}, finished, 1);
        if (fin_go) go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        if (fin_go) check({tag, "_go_in_fin_ignored"}, busy, 0);
        @(posedge clk); #1;
        check_trace(tag);
        check({tag, "_busy_low"}, busy, 0);
        if (hang) begin
            check({tag, "_timeout_err"}, timeout_err, 1);
        end else begin
            sb = 0;
            for (int a = 0; a < RS; a++) if (snk_mem[a] !== (DW'(a) ^ 16'hA5A5)) sb++;
            check({tag, "_sink_bad_words"}, sb, 0);
        end
    endtask

    task automatic reset_mid_stream();
        int n;
        prep(1'b0, 5, 1'b0, 1'b0);
        n = 0;
        while (!load_w && n < 100) begin @(posedge clk); #1; n++; end
        repeat (501) @(posedge clk);
        #1;
        check("din_word500", din, src_mem[500]);
        #1;
        reset = 1'b0;
        #1;
        check("reset_async_outputs",
              {busy, finished, load_w, load_data, start, src_rd, src_addr, din,
               timeout_err, snk_we, snk_addr, snk_data}, 0);
        check("pre_reset_trace_bad", run_bad, 0);
        exp_q.delete();
        run_bad = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; exp_fin = 0;
        reset = 1'b0; go = 1'b0; skip_w = 1'b0; clr_req = 1'b0;
        core_dl = 1; core_early = 1'b0; core_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {busy, finished, load_w, load_data, start, src_rd, src_addr, din,
               timeout_err, snk_we, snk_addr, snk_data}, 0);
        @(negedge clk); reset = 1'b1;

        run(1'b0, 1, 1'b0, 1'b0, 0, 1'b0, "full");
        run(1'b1, int'($urandom_range(1, 30)), 1'b0, 1'b0, 0, 1'b0, "skip_w");
        run(1'b1, 0, 1'b0, 1'b1, 0, 1'b0, "timeout");
        run(1'b1, int'($urandom_range(1, 30)), 1'b0, 1'b0, 300, 1'b0, "go_in_dstream");
        run(1'b1, 40, 1'b1, 1'b0, 0, 1'b1, "early_done");
        reset_mid_stream();
        run(1'b0, int'($urandom_range(1, 30)), 1'b0, 1'b0, 0, 1'b0, "after_reset");
        for (int r = 0; r < 2; r++)
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), 1'b0, 1'b0, 0, 1'b0, "random");
        check("finished_pulse_count", fin_cnt, exp_fin);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
